// File: rtl/seq_conv_alu.sv
// Execute-stage ALU with a sequential packed-lane dot-product (conv) engine.
// Latency: 1 cycle for ALU ops, LANES+1 cycles for conv/conv_acc (one MAC per cycle).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst                : clock (rising edge), async active-low reset
//   in_valid/in_ready       : request handshake; ALUControl, A, B sampled on accept
//   out_valid/out_ready     : result handshake; Result and flags stable while out_valid
//   Result, Carry, OverFlow, Zero, Negative : registered result and flags
//   busy                    : high while the MAC loop is running
module seq_conv_alu #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ALUControl,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Result,
  output logic              Carry,
  output logic              OverFlow,
  output logic              Zero,
  output logic              Negative,
  output logic              busy
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] psum, acc;
  logic [CW-1:0]     cnt;

  logic accept, is_conv, last_lane;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MAC);
  assign accept    = in_valid && in_ready;
  // 110 and 111 are the two conv opcodes
  assign is_conv   = (ALUControl[2:1] == 2'b11);
  assign last_lane = (cnt == CW'(LANES - 1));

  // ---------------- single-cycle ALU path ----------------
  logic              sub_sel;
  logic [DATA_W-1:0] b_in, sum;
  logic [DATA_W:0]   sum_full;
  logic              sum_ovf;
  logic [DATA_W-1:0] alu_res;
  logic              alu_arith;

  always_comb begin
    // slt shares the subtractor with sub
    sub_sel  = (ALUControl == 3'b001) || (ALUControl == 3'b101);
    b_in     = sub_sel ? ~B : B;
    sum_full = {1'b0, A} + {1'b0, b_in} + {{DATA_W{1'b0}}, sub_sel};
    sum      = sum_full[DATA_W-1:0];
    sum_ovf  = (A[DATA_W-1] == b_in[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
    alu_arith = (ALUControl[2:1] == 2'b00);
    alu_res  = '0;
    case (ALUControl)
      3'b000:  alu_res = sum;
      3'b001:  alu_res = sum;
      3'b010:  alu_res = A & B;
      3'b011:  alu_res = A | B;
      3'b100:  alu_res = B;
      3'b101:  alu_res = {{(DATA_W-1){1'b0}}, sum[DATA_W-1]};
      default: alu_res = '0;
    endcase
  end

  // ---------------- MAC lane path ----------------
  logic [DATA_W-1:0]          a_sh, b_sh;
  logic signed [LANE_W-1:0]   lane_a, lane_b;
  logic signed [2*LANE_W-1:0] prod;
  logic [DATA_W-1:0]          prod_ext, psum_nxt;

  always_comb begin
    a_sh     = a_q >> (cnt * LANE_W);
    b_sh     = b_q >> (cnt * LANE_W);
    lane_a   = a_sh[LANE_W-1:0];
    lane_b   = b_sh[LANE_W-1:0];
    prod     = lane_a * lane_b;
    // signed cast sign-extends the lane product to the full data width
    prod_ext = DATA_W'(prod);
    psum_nxt = psum + prod_ext;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_conv ? MAC : DONE;
      MAC:     if (last_lane) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q      <= '0;
      b_q      <= '0;
      psum     <= '0;
      acc      <= '0;
      cnt      <= '0;
      Result   <= '0;
      Carry    <= 1'b0;
      OverFlow <= 1'b0;
      Zero     <= 1'b0;
      Negative <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q <= A;
            b_q <= B;
            if (is_conv) begin
              // 111 starts from zero, 110 continues from the saved accumulator
              psum <= ALUControl[0] ? '0 : acc;
              cnt  <= '0;
            end else begin
              Result   <= alu_res;
              Carry    <= alu_arith & sum_full[DATA_W];
              OverFlow <= alu_arith & sum_ovf;
              Zero     <= (alu_res == '0);
              Negative <= alu_res[DATA_W-1];
            end
          end
        end
        MAC: begin
          psum <= psum_nxt;
          cnt  <= cnt + CW'(1);
          if (last_lane) begin
            Result   <= psum_nxt;
            acc      <= psum_nxt;
            Carry    <= 1'b0;
            OverFlow <= 1'b0;
            Zero     <= (psum_nxt == '0);
            Negative <= psum_nxt[DATA_W-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
